iomem_gpio: RTL and testbench

//   Parametrised GPIO peripheral on the PicoSoC iomem bus; next generation of the plain LED register.

---
 rtl/iomem_gpio.sv | 101 ++++++++++
 tb/tb_iomem_gpio.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/iomem_gpio.sv
// GPIO peripheral on the PicoSoC iomem bus: OUT/OE registers, atomic SET/CLR/TGL,
// synchronised inputs and rising-edge interrupt flags with per-bit enables.
module iomem_gpio #(
    parameter int         WIDTH       = 8,
    parameter logic [7:0] ADDR_PAGE   = 8'h03,
    parameter int         SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             iomem_valid,
    output logic             iomem_ready,
    input  logic [3:0]       iomem_wstrb,
    input  logic [31:0]      iomem_addr,
    input  logic [31:0]      iomem_wdata,
    output logic [31:0]      iomem_rdata,
    input  logic [WIDTH-1:0] gpio_in,
    output logic [WIDTH-1:0] gpio_out,
    output logic [WIDTH-1:0] gpio_oe,
    output logic             irq
);
    localparam logic [2:0] R_OUT    = 3'd0;
    localparam logic [2:0] R_OE     = 3'd1;
    localparam logic [2:0] R_IN     = 3'd2;
    localparam logic [2:0] R_SET    = 3'd3;
    localparam logic [2:0] R_CLR    = 3'd4;
    localparam logic [2:0] R_TGL    = 3'd5;
    localparam logic [2:0] R_IRQEN  = 3'd6;
    localparam logic [2:0] R_STATUS = 3'd7;

    logic [WIDTH-1:0] out_r, oe_r, irq_en_r, status_r, prev_r;
    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_r;
    logic [WIDTH-1:0] sync, rise, wmask, wbits;
    logic [31:0]      rd_val;
    logic [2:0]       ofs;
    logic             sel, wr;

    // Page-offset and low address bits are deliberately don't-care (register aliases).
    logic unused_bits;
    assign unused_bits = &{1'b0, iomem_addr[23:5], iomem_addr[1:0], iomem_wdata};

    assign sel  = iomem_valid && !iomem_ready && (iomem_addr[31:24] == ADDR_PAGE);
    assign wr   = |iomem_wstrb;
    assign ofs  = iomem_addr[4:2];
    assign sync = sync_r[SYNC_STAGES-1];
    assign rise = sync & ~prev_r;

    always_comb begin
        wmask = '0;
        for (int i = 0; i < WIDTH; i++) wmask[i] = iomem_wstrb[i/8];
        wbits = iomem_wdata[WIDTH-1:0] & wmask;
    end

    // Read mux; strobe registers (SET/CLR/TGL) always read as zero.
    always_comb begin
        rd_val = '0;
        case (ofs)
            R_OUT:    rd_val[WIDTH-1:0] = out_r;
            R_OE:     rd_val[WIDTH-1:0] = oe_r;
            R_IN:     rd_val[WIDTH-1:0] = sync;
            R_IRQEN:  rd_val[WIDTH-1:0] = irq_en_r;
            R_STATUS: rd_val[WIDTH-1:0] = status_r;
            default:  rd_val = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            out_r       <= '0;
            oe_r        <= '0;
            irq_en_r    <= '0;
            status_r    <= '0;
            sync_r      <= '0;
            prev_r      <= '0;
            iomem_ready <= 1'b0;
            iomem_rdata <= '0;
        end else begin
            iomem_ready <= sel;
            if (sel) iomem_rdata <= rd_val;
            sync_r   <= {sync_r[SYNC_STAGES-2:0], gpio_in};
            prev_r   <= sync;
            status_r <= status_r | rise;
            if (sel && wr) begin
                case (ofs)
                    R_OUT:    out_r    <= (out_r & ~wmask) | wbits;
                    R_OE:     oe_r     <= (oe_r & ~wmask) | wbits;
                    R_SET:    out_r    <= out_r | wbits;
                    R_CLR:    out_r    <= out_r & ~wbits;
                    R_TGL:    out_r    <= out_r ^ wbits;
                    R_IRQEN:  irq_en_r <= (irq_en_r & ~wmask) | wbits;
                    // A fresh edge on a bit being cleared keeps the flag set.
                    R_STATUS: status_r <= (status_r & ~wbits) | rise;
                    default:  ;
                endcase
            end
        end
    end

    assign gpio_out = out_r;
    assign gpio_oe  = oe_r;
    assign irq      = |(status_r & irq_en_r);
endmodule

// File: tb/tb_iomem_gpio.sv
// Bench for iomem_gpio: expected read data is queued per access and compared
// against what the bus returns on its ready pulse.
module tb_iomem_gpio;
    localparam int WIDTH = 8;
    localparam int SYNC  = 2;

    logic             clk = 0;
    logic             resetn = 0;
    logic             iomem_valid = 0;
    logic             iomem_ready;
    logic [3:0]       iomem_wstrb = 0;
    logic [31:0]      iomem_addr = 0;
    logic [31:0]      iomem_wdata = 0;
    logic [31:0]      iomem_rdata;
    logic [WIDTH-1:0] gpio_in = 0;
    logic [WIDTH-1:0] gpio_out, gpio_oe;
    logic             irq;

    int checks = 0;
    int failures = 0;

    logic [31:0] exp_q[$];
    logic [31:0] got_q[$];
    int          lat_q[$];
    int          wid_q[$];

    iomem_gpio #(.WIDTH(WIDTH), .ADDR_PAGE(8'h03), .SYNC_STAGES(SYNC)) dut (
        .clk(clk), .resetn(resetn),
        .iomem_valid(iomem_valid), .iomem_ready(iomem_ready),
        .iomem_wstrb(iomem_wstrb), .iomem_addr(iomem_addr),
        .iomem_wdata(iomem_wdata), .iomem_rdata(iomem_rdata),
        .gpio_in(gpio_in), .gpio_out(gpio_out), .gpio_oe(gpio_oe), .irq(irq)
    );

    always #5 clk = ~clk;

    // Drives one access and records rdata, cycles to ready and ready pulse width.
    task automatic bus_access(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
        int  n = 0;
        bit  seen = 0;
        @(negedge clk);
        iomem_addr = a; iomem_wstrb = s; iomem_wdata = d; iomem_valid = 1;
        while (n < 10 && !seen) begin
            @(posedge clk); #1;
            n++;
            if (iomem_ready) seen = 1;
        end
        if (seen) begin
            got_q.push_back(iomem_rdata);
            lat_q.push_back(n);
            iomem_valid = 0;
            @(posedge clk); #1;
            wid_q.push_back(iomem_ready ? 2 : 1);
        end else begin
            iomem_valid = 0;
            got_q.push_back('x);
            lat_q.push_back(-1);
            wid_q.push_back(0);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        logic [31:0] e, g;
        int l, w;
        resetn = 0;
        wait_cycles(3);
        checks++; if (gpio_out !== 8'h00) begin failures++; $display("FAIL reset_out got=%h exp=00", gpio_out); end
        checks++; if (gpio_oe !== 8'h00) begin failures++; $display("FAIL reset_oe got=%h exp=00", gpio_oe); end
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL reset_irq got=%b exp=0", irq); end
        checks++; if (iomem_ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", iomem_ready); end
        @(negedge clk); resetn = 1;
        exp_q.push_back(32'h0); bus_access(32'h0300_0000, 4'h0, 32'h0);
        exp_q.push_back(32'h0); bus_access(32'h0300_0004, 4'h0, 32'h0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); l = lat_q.pop_front(); w = wid_q.pop_front();
            checks++; if (g !== e) begin failures++; $display("FAIL reset_read got=%h exp=%h", g, e); end
            checks++; if (l !== 1) begin failures++; $display("FAIL reset_latency got=%0d exp=1", l); end
            checks++; if (w !== 1) begin failures++; $display("FAIL reset_ready_width got=%0d exp=1", w); end
        end
    endtask

    task automatic test_set_clr_tgl;
        logic [31:0] e, g;
        int l, w;
        exp_q.push_back(32'h0); bus_access(32'h0300_0000, 4'hF, 32'h0000_00A5);
        exp_q.push_back(32'h0); bus_access(32'h0300_000C, 4'hF, 32'h0000_000F);
        exp_q.push_back(32'h0); bus_access(32'h0300_0010, 4'hF, 32'h0000_0080);
        exp_q.push_back(32'h0); bus_access(32'h0300_0014, 4'hF, 32'h0000_0003);
        checks++; if (gpio_out !== 8'h2C) begin failures++; $display("FAIL sct_gpio_out got=%h exp=2c", gpio_out); end
        exp_q.push_back(32'h2C); bus_access(32'h0300_0000, 4'h0, 32'h0);
        exp_q.push_back(32'h0);  bus_access(32'h0300_0004, 4'hF, 32'hFFFF_FF3C);
        // Alias: upper page-offset bits must not change the register selected.
        exp_q.push_back(32'h3C); bus_access(32'h03AB_CDE4, 4'h0, 32'h0);
        checks++; if (gpio_oe !== 8'h3C) begin failures++; $display("FAIL sct_gpio_oe got=%h exp=3c", gpio_oe); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); l = lat_q.pop_front(); w = wid_q.pop_front();
            checks++; if (g !== e) begin failures++; $display("FAIL sct_rdata got=%h exp=%h", g, e); end
            checks++; if (l !== 1 || w !== 1) begin failures++; $display("FAIL sct_ready got_lat=%0d got_width=%0d exp=1/1", l, w); end
        end
    endtask

    task automatic test_byte_strobe;
        logic [31:0] e, g;
        int l, w;
        exp_q.push_back(32'h2C); bus_access(32'h0300_0000, 4'b0010, 32'h1234_5678);
        checks++; if (gpio_out !== 8'h2C) begin failures++; $display("FAIL strb_hi_out got=%h exp=2c", gpio_out); end
        exp_q.push_back(32'h2C); bus_access(32'h0300_0000, 4'b0001, 32'h1234_5678);
        checks++; if (gpio_out !== 8'h78) begin failures++; $display("FAIL strb_lo_out got=%h exp=78", gpio_out); end
        exp_q.push_back(32'h78); bus_access(32'h0300_0000, 4'h0, 32'h0);
        // IN is read-only: a write must leave it alone and return the pin value.
        exp_q.push_back(32'h0);  bus_access(32'h0300_0008, 4'hF, 32'hFFFF_FFFF);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); l = lat_q.pop_front(); w = wid_q.pop_front();
            checks++; if (g !== e) begin failures++; $display("FAIL strb_rdata got=%h exp=%h", g, e); end
            checks++; if (l !== 1 || w !== 1) begin failures++; $display("FAIL strb_ready got_lat=%0d got_width=%0d exp=1/1", l, w); end
        end
    endtask

    task automatic test_irq;
        logic [31:0] e, g;
        int l, w;
        exp_q.push_back(32'h0); bus_access(32'h0300_0018, 4'hF, 32'h0000_0004);
        @(negedge clk); gpio_in[2] = 1'b1;
        wait_cycles(SYNC + 2);
        checks++; if (irq !== 1'b1) begin failures++; $display("FAIL irq_rise got=%b exp=1", irq); end
        exp_q.push_back(32'h04); bus_access(32'h0300_001C, 4'h0, 32'h0);
        exp_q.push_back(32'h04); bus_access(32'h0300_0008, 4'h0, 32'h0);
        exp_q.push_back(32'h04); bus_access(32'h0300_001C, 4'hF, 32'h0000_0004);
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL irq_w1c got=%b exp=0", irq); end
        @(negedge clk); gpio_in[2] = 1'b0;
        wait_cycles(5);
        @(negedge clk); gpio_in[2] = 1'b1;
        wait_cycles(SYNC + 2);
        exp_q.push_back(32'h04); bus_access(32'h0300_001C, 4'h0, 32'h0);
        @(negedge clk); gpio_in[2] = 1'b0;
        wait_cycles(5);
        // New edge reaches STATUS on the same clock as the W1C write below.
        @(negedge clk); gpio_in[2] = 1'b1;
        repeat (SYNC) @(posedge clk);
        exp_q.push_back(32'h04); bus_access(32'h0300_001C, 4'hF, 32'h0000_0004);
        checks++; if (irq !== 1'b1) begin failures++; $display("FAIL irq_edge_wins got=%b exp=1", irq); end
        exp_q.push_back(32'h04); bus_access(32'h0300_001C, 4'h0, 32'h0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); l = lat_q.pop_front(); w = wid_q.pop_front();
            checks++; if (g !== e) begin failures++; $display("FAIL irq_rdata got=%h exp=%h", g, e); end
            checks++; if (l !== 1 || w !== 1) begin failures++; $display("FAIL irq_ready got_lat=%0d got_width=%0d exp=1/1", l, w); end
        end
    endtask

    task automatic test_page_miss;
        logic [31:0] e, g;
        int l, w;
        bit seen = 0;
        exp_q.push_back(32'h78); bus_access(32'h0300_0000, 4'h0, 32'h0);
        @(negedge clk);
        iomem_addr = 32'h0400_0000; iomem_wstrb = 4'hF; iomem_wdata = 32'hFF; iomem_valid = 1;
        repeat (6) begin @(posedge clk); #1; if (iomem_ready) seen = 1; end
        iomem_valid = 0;
        checks++; if (seen) begin failures++; $display("FAIL miss_ready got=1 exp=0"); end
        checks++; if (gpio_out !== 8'h78) begin failures++; $display("FAIL miss_out got=%h exp=78", gpio_out); end
        checks++; if (iomem_rdata !== 32'h78) begin failures++; $display("FAIL miss_rdata_hold got=%h exp=00000078", iomem_rdata); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); l = lat_q.pop_front(); w = wid_q.pop_front();
            checks++; if (g !== e) begin failures++; $display("FAIL miss_rdata got=%h exp=%h", g, e); end
            checks++; if (l !== 1 || w !== 1) begin failures++; $display("FAIL miss_pre_ready got_lat=%0d got_width=%0d exp=1/1", l, w); end
        end
    endtask

    task automatic test_reset_mid;
        logic [31:0] e, g;
        int l, w;
        bit seen = 0;
        @(negedge clk); gpio_in = '0;
        wait_cycles(5);
        @(negedge clk);
        iomem_addr = 32'h0300_0000; iomem_wstrb = 4'hF; iomem_wdata = 32'hFF; iomem_valid = 1;
        resetn = 0;
        repeat (4) begin @(posedge clk); #1; if (iomem_ready) seen = 1; end
        iomem_valid = 0;
        @(negedge clk); resetn = 1;
        checks++; if (seen) begin failures++; $display("FAIL rstmid_ready got=1 exp=0"); end
        checks++; if (gpio_out !== 8'h00) begin failures++; $display("FAIL rstmid_out got=%h exp=00", gpio_out); end
        checks++; if (gpio_oe !== 8'h00) begin failures++; $display("FAIL rstmid_oe got=%h exp=00", gpio_oe); end
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL rstmid_irq got=%b exp=0", irq); end
        exp_q.push_back(32'h0); bus_access(32'h0300_0018, 4'h0, 32'h0);
        exp_q.push_back(32'h0); bus_access(32'h0300_001C, 4'h0, 32'h0);
        exp_q.push_back(32'h0); bus_access(32'h0300_0000, 4'h0, 32'h0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); l = lat_q.pop_front(); w = wid_q.pop_front();
            checks++; if (g !== e) begin failures++; $display("FAIL rstmid_rdata got=%h exp=%h", g, e); end
            checks++; if (l !== 1 || w !== 1) begin failures++; $display("FAIL rstmid_retry_ready got_lat=%0d got_width=%0d exp=1/1", l, w); end
        end
    endtask

    initial begin
        test_reset();
        test_set_clr_tgl();
        test_byte_strobe();
        test_irq();
        test_page_miss();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end
endmodule
